// File: rtl/debounce_stage.sv
// -----------------------------------------------------------------------------
// debounce_stage
//
// Input conditioner placed directly in front of the single-bit storage flop.
// A raw, asynchronous, bouncy input is brought into the clock domain through a
// two-flop synchroniser. A four-state qualifier then accepts a new level only
// after the synchronised input has held it for STABLE_CYCLES consecutive
// clocks. Shorter excursions are dropped without any output activity.
//
// Outputs (all registered):
//   level - debounced level, feeds the storage flop data input
//   rise  - one-cycle pulse on an accepted 0->1 change
//   fall  - one-cycle pulse on an accepted 1->0 change
//   busy  - high while a candidate change is being qualified
//
// Optional build macro: DEBOUNCE_PRESS_COUNT_EN
//   When defined, an 8-bit wrapping press_count output counts accepted rising
//   edges. When undefined the port and its register do not exist and every
//   other output is cycle-identical.
//
// Reset is synchronous and active-high; there is no asynchronous reset path.
// -----------------------------------------------------------------------------
module debounce_stage #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw,
    output logic       level,
    output logic       rise,
    output logic       fall,
`ifdef DEBOUNCE_PRESS_COUNT_EN
    output logic       busy,
    output logic [7:0] press_count
`else
    output logic       busy
`endif
);

    // Qualifier states. The WAIT states are the only ones in which busy is set.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // Counter value at which the current clock is the last one needed to
    // accept a candidate (the first qualifying clock loads the counter with 1).
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

    // Synchroniser stages
    logic                 s1_r;
    logic                 s2_r;

    // Qualifier state
    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;

    // Registered outputs and their next values
    logic                 level_r;
    logic                 level_next_s;
    logic                 rise_r;
    logic                 rise_next_s;
    logic                 fall_r;
    logic                 fall_next_s;
    logic                 busy_r;
    logic                 busy_next_s;

    // Two-flop synchroniser: the qualifier only ever looks at s2_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
        end
    end

    // Next-state, counter and output decode for the qualifier.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        rise_next_s  = 1'b0;
        fall_next_s  = 1'b0;

        case (state_r)
            STABLE_LO: begin
                level_next_s = 1'b0;
                if (s2_r) begin
                    state_next_s = WAIT_HI;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end

            WAIT_HI: begin
                if (!s2_r) begin
                    // Candidate dropped before qualifying: silent rejection.
                    state_next_s = STABLE_LO;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = STABLE_HI;
                    cnt_next_s   = CNT_ZERO;
                    level_next_s = 1'b1;
                    rise_next_s  = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end

            STABLE_HI: begin
                level_next_s = 1'b1;
                if (!s2_r) begin
                    state_next_s = WAIT_LO;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end

            WAIT_LO: begin
                if (s2_r) begin
                    state_next_s = STABLE_HI;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = STABLE_LO;
                    cnt_next_s   = CNT_ZERO;
                    level_next_s = 1'b0;
                    fall_next_s  = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                // Unreachable encoding: recover to the idle-low state.
                state_next_s = STABLE_LO;
                cnt_next_s   = CNT_ZERO;
                level_next_s = 1'b0;
            end
        endcase

        busy_next_s = (state_next_s == WAIT_HI) || (state_next_s == WAIT_LO);
    end

    // Qualifier state register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= STABLE_LO;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
            busy_r  <= busy_next_s;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
    assign busy  = busy_r;

`ifdef DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_count_r;

    // Accepted-press counter; steps on the same edge that sets rise and wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            press_count_r <= 8'd0;
        end else if (rise_next_s) begin
            press_count_r <= press_count_r + 8'd1;
        end else begin
            press_count_r <= press_count_r;
        end
    end

    assign press_count = press_count_r;
`endif

endmodule

// File: tb/tb_debounce_stage.sv
// -----------------------------------------------------------------------------
// tb_debounce_stage
//
// Directed bench for debounce_stage with STABLE_CYCLES=4. A run-length model
// (how many consecutive edges the synchronised input has disagreed with the
// accepted level) predicts every output and is compared on each falling edge;
// hand-computed literal checks pin the model at the interesting cycles.
// Optional macro DEBOUNCE_PRESS_COUNT_EN enables the press counter checks.
// -----------------------------------------------------------------------------
module tb_debounce_stage;

    localparam int SC = 4;
    localparam int CW = 3;

    logic       clock;
    logic       reset;
    logic       raw;
    logic       level;
    logic       rise;
    logic       fall;
    logic       busy;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    debounce_stage #(
        .STABLE_CYCLES (SC),
        .CNT_WIDTH     (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .raw         (raw),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
`ifdef DEBOUNCE_PRESS_COUNT_EN
        .busy        (busy),
        .press_count (press_count)
`else
        .busy        (busy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt = total_cnt + 1;
        if (act == exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // raw_hist[0] is raw sampled one edge ago, raw_hist[1] two edges ago;
    // the qualifier observes what raw was two edges before the current one.
    logic [1:0] raw_hist;
    bit         model_valid = 1'b0;
    int         m_run;
    logic       m_level, m_rise, m_fall;
    int         m_count;

    // Model update on every rising edge, using the same sampled inputs as the DUT.
    always @(posedge clock) begin
        logic seen;
        if (reset) begin
            raw_hist    = 2'b00;
            m_run       = 0;
            m_level     = 1'b0;
            m_rise      = 1'b0;
            m_fall      = 1'b0;
            m_count     = 0;
            model_valid = 1'b1;
        end else begin
            seen     = raw_hist[1];
            raw_hist = {raw_hist[0], raw};
            m_rise   = 1'b0;
            m_fall   = 1'b0;
            if (seen != m_level) begin
                m_run = m_run + 1;
                if (m_run == SC) begin
                    m_level = seen;
                    m_rise  = seen;
                    m_fall  = !seen;
                    m_run   = 0;
                    if (seen) m_count = (m_count + 1) % 256;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Compare DUT against model on every falling edge once reset has been seen.
    always @(negedge clock) begin
        if (model_valid) begin
            check("level", int'(level), int'(m_level));
            check("rise",  int'(rise),  int'(m_rise));
            check("fall",  int'(fall),  int'(m_fall));
            check("busy",  int'(busy),  int'(m_run > 0));
            check("excl",  int'(rise & fall), 0);
`ifdef DEBOUNCE_PRESS_COUNT_EN
            check("press_count", int'(press_count), m_count);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic press_with_bounce();
        raw = 1'b1; step(SC + 3);
        raw = 1'b0; step(SC + 3);
        raw = 1'b1; step(1);
        raw = 1'b0; step(1);
        raw = 1'b1; step(2);
        raw = 1'b0; step(SC + 3);
    endtask

    int n_press;

    initial begin
        reset = 1'b1;
        raw   = 1'b0;
        step(2);
        reset = 1'b0;

        // Idle after reset with raw low: all outputs stay low.
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("idle_level", int'(level), 0);
            check("idle_busy",  int'(busy),  0);
            check("idle_rise",  int'(rise),  0);
        end

        // Clean press: raw rises before edge k.
        raw = 1'b1;
        step(1);                                   // after edge k
        step(1);                                   // k+1
        check("press_busy_k1", int'(busy), 0);
        step(1);                                   // k+2
        check("press_busy_k2", int'(busy), 1);
        step(2);                                   // k+4
        check("press_level_k4", int'(level), 0);
        step(1);                                   // k+5
        check("press_level_k5", int'(level), 1);
        check("press_rise_k5",  int'(rise),  1);
        check("press_busy_k5",  int'(busy),  0);
        step(1);                                   // k+6
        check("press_rise_k6",  int'(rise),  0);
        step(4);

        // Release: fall five edges after the change.
        raw = 1'b0;
        step(4);                                   // k+3
        check("rel_level_k3", int'(level), 1);
        step(1);                                   // k+4
        check("rel_fall_k4", int'(fall), 0);
        step(1);                                   // k+5
        check("rel_level_k5", int'(level), 0);
        check("rel_fall_k5",  int'(fall),  1);
        step(1);
        check("rel_fall_k6",  int'(fall),  0);
        step(3);

        // Glitch of SC-1 clocks: busy pulses, no rise.
        raw = 1'b1;
        step(3);                                   // after k+2
        check("glitch_busy", int'(busy), 1);
        raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_level", int'(level), 0);
            check("glitch_rise",  int'(rise),  0);
        end

        // Pulse of exactly SC clocks: accepted at k+5.
        raw = 1'b1;
        step(4);
        raw = 1'b0;
        step(1);                                   // after k+4
        check("edge_level_k4", int'(level), 0);
        step(1);                                   // k+5
        check("edge_rise_k5", int'(rise), 1);
        step(10);
        check("edge_release", int'(level), 0);

        // Reset during qualification with raw held high.
        raw = 1'b1;
        step(3);                                   // after k+2
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        step(1);
        check("mid_rst_busy",  int'(busy),  0);
        check("mid_rst_level", int'(level), 0);
        reset = 1'b0;
        step(5);                                   // after j+4
        check("mid_level_j4", int'(level), 0);
        step(1);                                   // j+5
        check("mid_level_j5", int'(level), 1);
        check("mid_rise_j5",  int'(rise),  1);
        step(3);
        raw = 1'b0;
        step(SC + 3);

        // Repeated presses with bounce bursts in between.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
`ifdef DEBOUNCE_PRESS_COUNT_EN
        n_press = 257;
`else
        n_press = 3;
`endif
        for (int p = 0; p < n_press; p++) press_with_bounce();
        check("loop_level", int'(level), 0);
`ifdef DEBOUNCE_PRESS_COUNT_EN
        check("press_count_wrap", int'(press_count), 1);
`endif
        step(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
